// File: rtl/n64_pkg.sv
// Shared N64 link definitions: command codes, response kinds and lengths, and
// the sequencer state encoding.
package n64_pkg;

   localparam logic [7:0] CMD_INFO   = 8'h00;
   localparam logic [7:0] CMD_STATUS = 8'h01;
   localparam logic [7:0] CMD_READ   = 8'h02;
   localparam logic [7:0] CMD_WRITE  = 8'h03;
   localparam logic [7:0] CMD_RESET  = 8'hFF;

   localparam logic [2:0] KIND_INFO      = 3'd0;
   localparam logic [2:0] KIND_STATUS    = 3'd1;
   localparam logic [2:0] KIND_READ_DATA = 3'd2;
   localparam logic [2:0] KIND_WRITE_CRC = 3'd3;

   localparam logic [5:0] LEN_INFO      = 6'd3;
   localparam logic [5:0] LEN_STATUS    = 6'd4;
   localparam logic [5:0] LEN_READ_DATA = 6'd33;
   localparam logic [5:0] LEN_WRITE_CRC = 6'd1;

   typedef enum logic [2:0] {
      ST_RX,
      ST_DECODE,
      ST_MEM,
      ST_TURN,
      ST_TX,
      ST_DONE
   } seq_state_t;

endpackage

// File: rtl/n64_cmd_decode.sv
// Combinational N64 command decoder: maps a command byte to its response kind
// and length, and flags commands that need a memory read or a buffer commit.
module n64_cmd_decode
   import n64_pkg::*;
(
   input  logic [7:0] cmd,
   output logic [2:0] kind,
   output logic [5:0] len,
   output logic       valid,
   output logic       needs_mem,
   output logic       is_write
);

   always_comb begin
      kind      = KIND_INFO;
      len       = '0;
      valid     = 1'b0;
      needs_mem = 1'b0;
      is_write  = 1'b0;
      case (cmd)
         CMD_INFO, CMD_RESET: begin
            kind  = KIND_INFO;
            len   = LEN_INFO;
            valid = 1'b1;
         end
         CMD_STATUS: begin
            kind  = KIND_STATUS;
            len   = LEN_STATUS;
            valid = 1'b1;
         end
         CMD_READ: begin
            kind      = KIND_READ_DATA;
            len       = LEN_READ_DATA;
            valid     = 1'b1;
            needs_mem = 1'b1;
         end
         CMD_WRITE: begin
            kind     = KIND_WRITE_CRC;
            len      = LEN_WRITE_CRC;
            valid    = 1'b1;
            is_write = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/n64_link_sequencer.sv
// N64 serial link sequencer: command completion -> decode -> optional memory read
// -> bus turnaround -> transmit supervision. Optional MEM/TX abort: N64_SEQ_TIMEOUT_EN.
module n64_link_sequencer
   import n64_pkg::*;
#(
   parameter int TURNAROUND_CYCLES = 16,
   parameter int TIMEOUT_CYCLES    = 8192,
   parameter int CNT_W             = 14
) (
   input  logic        sample_clk,
   input  logic        reset,
   input  logic        rx_handoff,
   input  logic [7:0]  rx_cmd,
   input  logic [15:0] rx_address,
   input  logic [7:0]  rx_crc,
   input  logic        tx_done,
   input  logic        mem_rd_ack,
   output logic        cur_operation,
   output logic        tx_start,
   output logic [2:0]  tx_kind,
   output logic [5:0]  tx_len,
   output logic [7:0]  tx_crc,
   output logic        mem_rd_req,
   output logic [15:0] mem_rd_addr,
   output logic        mem_wr_commit,
   output logic        busy,
   output logic [7:0]  cmd_count,
   output logic        timeout_err
);

   // A zero turnaround still costs one counting cycle.
   localparam logic [CNT_W-1:0] TURN_LAST =
      (TURNAROUND_CYCLES <= 1) ? '0 : CNT_W'(TURNAROUND_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef N64_SEQ_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   seq_state_t        state_q, state_d;
   logic              rx_prev_q;
   logic [7:0]        cmd_q, cmd_d;
   logic [15:0]       addr_q, addr_d;
   logic [7:0]        crc_q, crc_d;
   logic [CNT_W-1:0]  counter_q, counter_d;
   logic              tx_start_q, tx_start_d;
   logic [2:0]        tx_kind_q, tx_kind_d;
   logic [5:0]        tx_len_q, tx_len_d;
   logic [7:0]        tx_crc_q, tx_crc_d;
   logic              mem_rd_req_q, mem_rd_req_d;
   logic [15:0]       mem_rd_addr_q, mem_rd_addr_d;
   logic              cur_op_q, cur_op_d;
   logic [7:0]        cmd_count_q, cmd_count_d;
   logic              timeout_err_q, timeout_err_d;

   logic              rx_event, waiting, timeout_hit;
   logic [2:0]        dec_kind;
   logic [5:0]        dec_len;
   logic              dec_valid, dec_needs_mem, dec_is_write;

   n64_cmd_decode u_decode (
      .cmd       (cmd_q),
      .kind      (dec_kind),
      .len       (dec_len),
      .valid     (dec_valid),
      .needs_mem (dec_needs_mem),
      .is_write  (dec_is_write)
   );

   assign rx_event    = rx_handoff & ~rx_prev_q;
   assign waiting     = (state_q == ST_MEM) || (state_q == ST_TX);
   assign timeout_hit = TIMEOUT_EN && waiting && (counter_q == TIMEOUT_LAST);

   always_comb begin
      state_d       = state_q;
      cmd_d         = cmd_q;
      addr_d        = addr_q;
      crc_d         = crc_q;
      tx_start_d    = 1'b0;
      tx_kind_d     = tx_kind_q;
      tx_len_d      = tx_len_q;
      tx_crc_d      = tx_crc_q;
      mem_rd_req_d  = mem_rd_req_q;
      mem_rd_addr_d = mem_rd_addr_q;
      cmd_count_d   = cmd_count_q;
      timeout_err_d = 1'b0;
      mem_wr_commit = 1'b0;
      case (state_q)
         ST_RX: begin
            if (rx_event) begin
               state_d = ST_DECODE;
               cmd_d   = rx_cmd;
               addr_d  = rx_address;
               crc_d   = rx_crc;
            end
         end
         ST_DECODE: begin
            if (dec_valid) begin
               tx_kind_d = dec_kind;
               tx_len_d  = dec_len;
               state_d   = ST_TURN;
               if (dec_needs_mem) begin
                  mem_rd_addr_d = addr_q;
                  mem_rd_req_d  = 1'b1;
                  state_d       = ST_MEM;
               end
               if (dec_is_write) begin
                  tx_crc_d      = crc_q;
                  mem_wr_commit = 1'b1;
               end
            end else begin
               state_d = ST_RX;
            end
         end
         ST_MEM: begin
            if (timeout_hit) begin
               state_d       = ST_RX;
               mem_rd_req_d  = 1'b0;
               timeout_err_d = 1'b1;
            end else if (mem_rd_ack) begin
               mem_rd_req_d = 1'b0;
               state_d      = ST_TURN;
            end
         end
         ST_TURN: begin
            if (counter_q == TURN_LAST) begin
               tx_start_d = 1'b1;
               state_d    = ST_TX;
            end
         end
         ST_TX: begin
            if (timeout_hit) begin
               state_d       = ST_RX;
               timeout_err_d = 1'b1;
            end else if (tx_done) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            cmd_count_d = cmd_count_q + 8'd1;
            state_d     = ST_RX;
         end
         default: state_d = ST_RX;
      endcase

      // One counter serves turnaround and (optionally) the wait timeouts; it restarts on every state change.
      counter_d = '0;
      if ((state_d == state_q) && ((state_q == ST_TURN) || (TIMEOUT_EN && waiting))) begin
         counter_d = counter_q + CNT_W'(1);
      end
      cur_op_d = (state_d == ST_TURN) || (state_d == ST_TX);
   end

   always_ff @(posedge sample_clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_RX;
         rx_prev_q     <= 1'b0;
         cmd_q         <= '0;
         addr_q        <= '0;
         crc_q         <= '0;
         counter_q     <= '0;
         tx_start_q    <= 1'b0;
         tx_kind_q     <= '0;
         tx_len_q      <= '0;
         tx_crc_q      <= '0;
         mem_rd_req_q  <= 1'b0;
         mem_rd_addr_q <= '0;
         cur_op_q      <= 1'b0;
         cmd_count_q   <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rx_prev_q     <= rx_handoff;
         cmd_q         <= cmd_d;
         addr_q        <= addr_d;
         crc_q         <= crc_d;
         counter_q     <= counter_d;
         tx_start_q    <= tx_start_d;
         tx_kind_q     <= tx_kind_d;
         tx_len_q      <= tx_len_d;
         tx_crc_q      <= tx_crc_d;
         mem_rd_req_q  <= mem_rd_req_d;
         mem_rd_addr_q <= mem_rd_addr_d;
         cur_op_q      <= cur_op_d;
         cmd_count_q   <= cmd_count_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign cur_operation = cur_op_q;
   assign tx_start      = tx_start_q;
   assign tx_kind       = tx_kind_q;
   assign tx_len        = tx_len_q;
   assign tx_crc        = tx_crc_q;
   assign mem_rd_req    = mem_rd_req_q;
   assign mem_rd_addr   = mem_rd_addr_q;
   assign busy          = (state_q != ST_RX);
   assign cmd_count     = cmd_count_q;
   assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_n64_link_sequencer.sv
// Directed bench for n64_link_sequencer: table of commands plus hand-written
// reset, memory-ack and timeout sequences.
module tb_n64_link_sequencer;

   localparam int TURN = 16;
`ifdef N64_SEQ_TIMEOUT_EN
   localparam int TOUT = 64;
`else
   localparam int TOUT = 8192;
`endif

   logic        sample_clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_handoff = 1'b0;
   logic [7:0]  rx_cmd = '0;
   logic [15:0] rx_address = '0;
   logic [7:0]  rx_crc = '0;
   logic        tx_done = 1'b0;
   logic        mem_rd_ack = 1'b0;
   logic        cur_operation, tx_start, mem_rd_req, mem_wr_commit, busy, timeout_err;
   logic [2:0]  tx_kind;
   logic [5:0]  tx_len;
   logic [7:0]  tx_crc, cmd_count;
   logic [15:0] mem_rd_addr;

   int checks = 0;
   int failures = 0;
   int exp_count = 0;
   logic [7:0]  last_crc = '0;
   logic [15:0] last_addr = '0;

   typedef struct {
      logic [7:0]  cmd;
      logic [15:0] addr;
      logic [7:0]  crc;
      int          ack_wait;
      bit          valid;
      logic [2:0]  kind;
      logic [5:0]  len;
      bit          mem;
      bit          wr;
   } vec_t;

   vec_t vecs[9];

   always #5 sample_clk = ~sample_clk;

   n64_link_sequencer #(
      .TURNAROUND_CYCLES (TURN),
      .TIMEOUT_CYCLES    (TOUT),
      .CNT_W             (14)
   ) dut (
      .sample_clk    (sample_clk),
      .reset         (reset),
      .rx_handoff    (rx_handoff),
      .rx_cmd        (rx_cmd),
      .rx_address    (rx_address),
      .rx_crc        (rx_crc),
      .tx_done       (tx_done),
      .mem_rd_ack    (mem_rd_ack),
      .cur_operation (cur_operation),
      .tx_start      (tx_start),
      .tx_kind       (tx_kind),
      .tx_len        (tx_len),
      .tx_crc        (tx_crc),
      .mem_rd_req    (mem_rd_req),
      .mem_rd_addr   (mem_rd_addr),
      .mem_wr_commit (mem_wr_commit),
      .busy          (busy),
      .cmd_count     (cmd_count),
      .timeout_err   (timeout_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int cyc, commits, starts, lat_exp;
      commits = 0;
      starts  = 0;
      cyc     = 0;
      rx_cmd     = v.cmd;
      rx_address = v.addr;
      rx_crc     = v.crc;
      rx_handoff = 1'b1;
      if (!v.valid) begin
         for (int i = 0; i < 25; i++) begin
            @(negedge sample_clk);
            rx_handoff = 1'b0;
            starts  += int'(tx_start);
            commits += int'(mem_wr_commit);
         end
         check("bad_no_start", starts, 0);
         check("bad_no_commit", commits, 0);
         check("bad_idle", busy, 1'b0);
         check("bad_count", cmd_count, exp_count);
         $display("vec %0d cmd=%02h rejected count=%0d", idx, v.cmd, cmd_count);
         return;
      end
      if (v.mem) begin
         while (!mem_rd_req && cyc < 10) begin
            @(negedge sample_clk);
            rx_handoff = 1'b0;
            cyc++;
         end
         check("rd_req_rise", mem_rd_req, 1'b1);
         check("rd_req_cycle", cyc, 2);
         check("rd_addr", mem_rd_addr, v.addr);
         for (int i = 0; i < v.ack_wait; i++) @(negedge sample_clk);
         check("rd_req_held", mem_rd_req, 1'b1);
         mem_rd_ack = 1'b1;
         @(negedge sample_clk);
         mem_rd_ack = 1'b0;
         check("rd_req_drop", mem_rd_req, 1'b0);
         cyc = 1;
         lat_exp = TURN + 1;
         last_addr = v.addr;
      end else begin
         lat_exp = TURN + 2;
      end
      while (!tx_start && cyc < 60) begin
         @(negedge sample_clk);
         rx_handoff = 1'b0;
         cyc++;
         commits += int'(mem_wr_commit);
      end
      if (v.wr) last_crc = v.crc;
      check("latency", cyc, lat_exp);
      check("tx_kind", tx_kind, v.kind);
      check("tx_len", tx_len, v.len);
      check("tx_crc", tx_crc, last_crc);
      check("mem_rd_addr", mem_rd_addr, last_addr);
      check("tx_curop", cur_operation, 1'b1);
      check("commit_pulses", commits, v.wr ? 1 : 0);
      $display("vec %0d cmd=%02h latency=%0d kind=%0d len=%0d crc=%02h", idx, v.cmd, cyc, tx_kind, tx_len, tx_crc);
      @(negedge sample_clk);
      check("start_pulse", tx_start, 1'b0);
      rx_handoff = 1'b1;
      @(negedge sample_clk);
      rx_handoff = 1'b0;
      repeat (2) @(negedge sample_clk);
      check("tx_hold", cur_operation, 1'b1);
      tx_done = 1'b1;
      @(negedge sample_clk);
      tx_done = 1'b0;
      check("done_curop", cur_operation, 1'b0);
      check("done_busy", busy, 1'b1);
      @(negedge sample_clk);
      exp_count = (exp_count + 1) % 256;
      check("count", cmd_count, exp_count);
      check("idle", busy, 1'b0);
      repeat (3) @(negedge sample_clk);
      check("tx_handoff_ignored", busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, starts, errs;
      vecs[0] = '{8'h01, 16'h0000, 8'h00, 0, 1'b1, 3'd1, 6'd4,  1'b0, 1'b0};
      vecs[1] = '{8'h02, 16'h8020, 8'h00, 5, 1'b1, 3'd2, 6'd33, 1'b1, 1'b0};
      vecs[2] = '{8'h03, 16'h0040, 8'hA5, 0, 1'b1, 3'd3, 6'd1,  1'b0, 1'b1};
      vecs[3] = '{8'h7E, 16'h0000, 8'h00, 0, 1'b0, 3'd0, 6'd0,  1'b0, 1'b0};
      vecs[4] = '{8'h00, 16'h0000, 8'h11, 0, 1'b1, 3'd0, 6'd3,  1'b0, 1'b0};
      vecs[5] = '{8'h02, 16'h1234, 8'h00, 0, 1'b1, 3'd2, 6'd33, 1'b1, 1'b0};
      vecs[6] = '{8'hFF, 16'h0000, 8'h00, 0, 1'b1, 3'd0, 6'd3,  1'b0, 1'b0};
      vecs[7] = '{8'h04, 16'h0000, 8'h00, 0, 1'b0, 3'd0, 6'd0,  1'b0, 1'b0};
      vecs[8] = '{8'h03, 16'h0000, 8'h3C, 0, 1'b1, 3'd3, 6'd1,  1'b0, 1'b1};

      repeat (3) @(negedge sample_clk);
      check("rst_curop", cur_operation, 1'b0);
      check("rst_start", tx_start, 1'b0);
      check("rst_rdreq", mem_rd_req, 1'b0);
      check("rst_commit", mem_wr_commit, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_tx_fields", {tx_kind, tx_len, tx_crc}, 17'h0);
      check("rst_rd_addr", mem_rd_addr, 16'h0);
      check("rst_count", cmd_count, 8'h0);
      check("rst_timeout", timeout_err, 1'b0);
      reset = 1'b0;
      repeat (2) @(negedge sample_clk);

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // Withhold tx_done after a STATUS command.
      rx_cmd = 8'h01;
      rx_handoff = 1'b1;
      cyc = 0;
      while (!tx_start && cyc < 60) begin
         @(negedge sample_clk);
         rx_handoff = 1'b0;
         cyc++;
      end
      check("to_start", tx_start, 1'b1);
`ifdef N64_SEQ_TIMEOUT_EN
      cyc = 0;
      while (!timeout_err && cyc < 200) begin
         @(negedge sample_clk);
         cyc++;
      end
      check("timeout_cycle", cyc, TOUT);
      check("timeout_busy", busy, 1'b0);
      check("timeout_curop", cur_operation, 1'b0);
      @(negedge sample_clk);
      check("timeout_pulse", timeout_err, 1'b0);
      check("timeout_count", cmd_count, exp_count);
      $display("timeout after %0d cycles count=%0d", cyc, cmd_count);
`else
      errs = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge sample_clk);
         errs += int'(timeout_err);
      end
      check("no_timeout", errs, 0);
      check("tx_wait_busy", busy, 1'b1);
      tx_done = 1'b1;
      @(negedge sample_clk);
      tx_done = 1'b0;
      @(negedge sample_clk);
      exp_count = (exp_count + 1) % 256;
      check("long_tx_count", cmd_count, exp_count);
      $display("long tx wait completed count=%0d", cmd_count);
`endif
      repeat (2) @(negedge sample_clk);

      // Reset during MEM drops the read request immediately.
      rx_cmd = 8'h02;
      rx_address = 16'hBEEF;
      rx_handoff = 1'b1;
      repeat (3) begin
         @(negedge sample_clk);
         rx_handoff = 1'b0;
      end
      check("mem_before_rst", mem_rd_req, 1'b1);
      #1 reset = 1'b1;
      #1;
      check("rst_mem_req", mem_rd_req, 1'b0);
      check("rst_mem_busy", busy, 1'b0);
      @(negedge sample_clk);
      reset = 1'b0;
      $display("reset in MEM req=%0d busy=%0d", mem_rd_req, busy);

      // Reset during TURN after STATUS: no launch afterwards.
      rx_cmd = 8'h01;
      rx_handoff = 1'b1;
      repeat (8) begin
         @(negedge sample_clk);
         rx_handoff = 1'b0;
      end
      check("turn_curop", cur_operation, 1'b1);
      #1 reset = 1'b1;
      #1;
      check("rst_turn_curop", cur_operation, 1'b0);
      check("rst_turn_busy", busy, 1'b0);
      @(negedge sample_clk);
      reset = 1'b0;
      starts = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge sample_clk);
         starts += int'(tx_start);
      end
      check("rst_turn_no_start", starts, 0);
      check("rst_turn_count", cmd_count, 8'h0);
      check("rst_turn_kind", tx_kind, 3'd0);
      $display("reset in TURN starts=%0d count=%0d", starts, cmd_count);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
